// File: rtl/imem_loader.sv
// Byte-serial program loader: packs MSB-first bytes into 32-bit words, writes
// them into IMEM and holds the MIPS system in reset until the program is in.
module imem_loader #(
  parameter int DEPTH = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in_byte,
  input  logic                       in_last,
  output logic                       in_ready,
  input  logic                       reload,
  output logic                       imem_we,
  output logic [$clog2(DEPTH)-1:0]   imem_addr,
  output logic [31:0]                imem_wd,
  output logic                       cpu_reset,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(DEPTH):0]     word_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, ASSEMBLE, WRITE, DONE, ERROR} state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   wd_q, wd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic          accept;

  assign in_ready   = (state_q == IDLE) || (state_q == ASSEMBLE);
  assign accept     = in_valid && in_ready;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wd    = wd_q;
  assign word_count = count_q;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERROR);
  assign cpu_reset  = (state_q != DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wd_q    <= '0;
      addr_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      last_q  <= last_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    addr_d  = addr_q;
    count_d = count_q;
    last_d  = last_q;
    we_d    = 1'b0;
    case (state_q)
      IDLE, ASSEMBLE: begin
        if (accept) begin
          // Byte k lands at bit offset 8*(3-k); ~idx_q is exactly 3-k.
          wd_d[{~idx_q, 3'b000} +: 8] = in_byte;
          if (in_last || (idx_q == 2'd3)) begin
            state_d = WRITE;
            last_d  = in_last;
            we_d    = 1'b1;
          end else begin
            state_d = ASSEMBLE;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      WRITE: begin
        idx_d   = '0;
        wd_d    = '0;
        count_d = count_q + (AW+1)'(1);
        if (last_q) begin
          state_d = DONE;
          if (addr_q != LastAddr) addr_d = addr_q + AW'(1);
        end else if (addr_q == LastAddr) begin
          state_d = ERROR;
        end else begin
          state_d = IDLE;
          addr_d  = addr_q + AW'(1);
        end
      end
      DONE, ERROR: begin
        if (reload) begin
          state_d = IDLE;
          idx_d   = '0;
          wd_d    = '0;
          addr_d  = '0;
          count_d = '0;
          last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
